// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - steps through a song ROM and drives the tone generator
// One word per note; articulation gap, rests, pause/resume, stop and looping.
module song_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int GAP_CYCLES     = 1000000,
  parameter int FULL_NOTE_BITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic                      loop,
  input  logic [FULL_NOTE_BITS-1:0] full_note_cfg,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      snd_en,
  output logic [2:0]                snd_octave,
  output logic [2:0]                snd_note,
  output logic [2:0]                snd_length,
  output logic [FULL_NOTE_BITS-1:0] snd_full_note,
  input  logic                      snd_over,
  output logic                      mute,
  output logic                      busy,
  output logic                      done
);

  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ARM, S_PLAY, S_GAP, S_PAUSE
  } state_t;

  state_t                      state, state_n;
  logic [ADDR_W-1:0]           rom_addr_n;
  logic                        snd_en_n, mute_n, busy_n, done_n;
  logic [2:0]                  octave_n, note_n, length_n;
  logic [FULL_NOTE_BITS-1:0]   full_note_n;
  logic [CNT_W-1:0]            gap_cnt, gap_cnt_n;
  logic                        from_gap, from_gap_n;
  logic                        note_mute, note_mute_n;
  logic                        go_pause, do_advance, do_end, go_idle;

  logic       word_end, word_rest;
  logic [2:0] word_note;
  logic       unused_rom_bits;

  assign word_end        = rom_data[15];
  assign word_note       = rom_data[10:8];
  assign word_rest       = rom_data[14] | (word_note == 3'd7);
  assign unused_rom_bits = ^rom_data[4:0];

  always_comb begin
    state_n     = state;
    rom_addr_n  = rom_addr;
    snd_en_n    = snd_en;
    octave_n    = snd_octave;
    note_n      = snd_note;
    length_n    = snd_length;
    full_note_n = snd_full_note;
    mute_n      = mute;
    done_n      = 1'b0;
    gap_cnt_n   = gap_cnt;
    from_gap_n  = from_gap;
    note_mute_n = note_mute;
    go_pause    = 1'b0;
    do_advance  = 1'b0;
    do_end      = 1'b0;
    go_idle     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          full_note_n = full_note_cfg;
          rom_addr_n  = '0;
          state_n     = S_FETCH;
        end
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        if (word_end) begin
          do_end = 1'b1;
        end else begin
          octave_n    = rom_data[13:11];
          note_n      = word_note;
          length_n    = rom_data[7:5];
          note_mute_n = word_rest;
          from_gap_n  = 1'b0;
          if (pause) begin
            snd_en_n = 1'b0;
            mute_n   = 1'b1;
            state_n  = S_PAUSE;
          end else begin
            snd_en_n = 1'b1;
            mute_n   = word_rest;
            state_n  = S_ARM;
          end
        end
      end
      // over stays high while the generator is disabled, so only its fall means "started"
      S_ARM: begin
        if (pause)          go_pause = 1'b1;
        else if (!snd_over) state_n  = S_PLAY;
      end
      S_PLAY: begin
        if (pause) begin
          go_pause = 1'b1;
        end else if (snd_over) begin
          snd_en_n  = 1'b0;
          mute_n    = 1'b1;
          gap_cnt_n = CNT_W'(GAP_CYCLES - 1);
          state_n   = S_GAP;
        end
      end
      S_GAP: begin
        if (pause)                go_pause   = 1'b1;
        else if (gap_cnt == '0)   do_advance = 1'b1;
        else                      gap_cnt_n  = gap_cnt - 1'b1;
      end
      S_PAUSE: begin
        if (!pause) begin
          if (from_gap) begin
            do_advance = 1'b1;
          end else begin
            snd_en_n = 1'b1;
            mute_n   = note_mute;
            state_n  = S_ARM;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (go_pause) begin
      snd_en_n   = 1'b0;
      mute_n     = 1'b1;
      from_gap_n = (state == S_GAP);
      state_n    = S_PAUSE;
    end

    // running off the last address ends the song exactly like an END word
    if (do_advance) begin
      if (&rom_addr) begin
        do_end = 1'b1;
      end else begin
        rom_addr_n = rom_addr + 1'b1;
        state_n    = S_FETCH;
      end
    end

    if (do_end) begin
      if (loop) begin
        rom_addr_n = '0;
        state_n    = S_FETCH;
      end else begin
        go_idle = 1'b1;
        done_n  = 1'b1;
      end
    end

    if (go_idle || stop) begin
      state_n     = S_IDLE;
      rom_addr_n  = '0;
      snd_en_n    = 1'b0;
      octave_n    = '0;
      note_n      = '0;
      length_n    = '0;
      full_note_n = '0;
      mute_n      = 1'b1;
    end
    if (stop) done_n = 1'b0;

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      rom_addr      <= '0;
      snd_en        <= 1'b0;
      snd_octave    <= '0;
      snd_note      <= '0;
      snd_length    <= '0;
      snd_full_note <= '0;
      mute          <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      gap_cnt       <= '0;
      from_gap      <= 1'b0;
      note_mute     <= 1'b1;
    end else begin
      state         <= state_n;
      rom_addr      <= rom_addr_n;
      snd_en        <= snd_en_n;
      snd_octave    <= octave_n;
      snd_note      <= note_n;
      snd_length    <= length_n;
      snd_full_note <= full_note_n;
      mute          <= mute_n;
      busy          <= busy_n;
      done          <= done_n;
      gap_cnt       <= gap_cnt_n;
      from_gap      <= from_gap_n;
      note_mute     <= note_mute_n;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - self-checking bench for song_sequencer
// Behavioural ROM, tone generator and song model; directed plus random songs.
module tb_song_sequencer;

  localparam int GAP = 5;

  logic        clk = 1'b0;
  logic        rst, start, stop, pause, loop;
  logic [2:0]  full_note_cfg;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data;
  logic        snd_en, mute, busy, done;
  logic [2:0]  snd_octave, snd_note, snd_length, snd_full_note;
  logic        snd_over;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [4];

  song_sequencer #(.ADDR_W(2), .DATA_W(16), .GAP_CYCLES(GAP), .FULL_NOTE_BITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop(loop),
    .full_note_cfg(full_note_cfg), .rom_addr(rom_addr), .rom_data(rom_data),
    .snd_en(snd_en), .snd_octave(snd_octave), .snd_note(snd_note), .snd_length(snd_length),
    .snd_full_note(snd_full_note), .snd_over(snd_over), .mute(mute), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // tone generator: over held high while disabled, counters cleared when en is low
  int tcnt = 0;
  int tdur = 2;
  always @(posedge clk) begin
    if (!snd_en) begin
      snd_over <= 1'b1;
      tcnt     <= 0;
      tdur     <= 2 + $urandom_range(0, 3);
    end else if (tcnt >= tdur) begin
      snd_over <= 1'b1;
    end else begin
      snd_over <= 1'b0;
      tcnt     <= tcnt + 1;
    end
  end

  // observed notes as {full_note, octave, note, length, mute}
  logic [12:0] cap_q [$];
  int          gaps_q [$];
  logic [1:0]  addr_q [$];
  int          done_cnt = 0, done_busy = 0, field_chg = 0, low_run = 0;
  bit          seen = 0, prev_en = 0;
  logic [1:0]  prev_addr = 2'd0;
  logic [12:0] cur = '0;

  always @(negedge clk) begin
    if (snd_en && !prev_en) begin
      if (seen) gaps_q.push_back(low_run);
      seen    = 1;
      low_run = 0;
      cur     = {snd_full_note, snd_octave, snd_note, snd_length, mute};
      cap_q.push_back(cur);
    end else if (snd_en && ({snd_full_note, snd_octave, snd_note, snd_length, mute} !== cur)) begin
      field_chg++;
    end
    if (!busy) begin
      seen    = 0;
      low_run = 0;
    end else if (!snd_en) begin
      low_run++;
    end
    if (done) begin
      done_cnt++;
      if (busy) done_busy++;
    end
    if (rom_addr !== prev_addr) addr_q.push_back(rom_addr);
    prev_addr = rom_addr;
    prev_en   = snd_en;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  function automatic logic [15:0] mk(logic e, logic r, logic [2:0] o, logic [2:0] n, logic [2:0] l);
    return {e, r, o, n, l, 5'b0};
  endfunction

  function automatic logic [12:0] expect_word(logic [2:0] cfg, logic [15:0] w);
    return {cfg, w[13:11], w[10:8], w[7:5], w[14] | (w[10:8] == 3'd7)};
  endfunction

  task automatic check_idle(string tag);
    check({tag, "_en"}, snd_en, 1'b0);
    check({tag, "_mute"}, mute, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_fields"}, {rom_addr, snd_octave, snd_note, snd_length, snd_full_note}, 14'd0);
  endtask

  task automatic wait_en(logic v, string tag);
    int n = 0;
    while (snd_en !== v && n < 400) begin tick(1); n++; end
    check(tag, snd_en, v);
  endtask

  task automatic wait_done(int target, string tag);
    int n = 0;
    while (done_cnt < target && n < 600) begin tick(1); n++; end
    check(tag, done_cnt, target);
  endtask

  task automatic wait_notes(int target, string tag);
    int n = 0;
    while (cap_q.size() < target && n < 600) begin tick(1); n++; end
    check(tag, cap_q.size() >= target, 1'b1);
  endtask

  // expected song: notes in address order until END or the last address, no loop
  task automatic play_song(string tag, logic [2:0] cfg);
    logic [12:0] exp_q [$];
    int cb, gb, db;
    for (int a = 0; a < 4; a++) begin
      if (rom[a][15]) break;
      exp_q.push_back(expect_word(cfg, rom[a]));
    end
    cb = cap_q.size(); gb = gaps_q.size(); db = done_cnt;
    full_note_cfg = cfg;
    pulse_start();
    wait_done(db + 1, {tag, "_done"});
    tick(2);
    check({tag, "_count"}, cap_q.size() - cb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (cb + i < cap_q.size()) check($sformatf("%s_note%0d", tag, i), cap_q[cb + i], exp_q[i]);
    // gap, then FETCH and DECODE of the next word
    for (int i = gb; i < gaps_q.size(); i++) check($sformatf("%s_gap%0d", tag, i - gb), gaps_q[i], GAP + 2);
    check({tag, "_one_done"}, done_cnt - db, 1);
    check_idle({tag, "_end"});
  endtask

  initial begin
    int ab, cb, db;
    logic [15:0] w;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0; full_note_cfg = 3'd0;
    rom[0] = '0; rom[1] = '0; rom[2] = '0; rom[3] = '0;
    tick(3);
    check_idle("reset");
    rst = 1'b0;
    tick(2);
    check_idle("idle");

    // basic two-note song
    rom[0] = mk(0, 0, 3'd4, 3'd0, 3'd2); rom[1] = mk(0, 0, 3'd5, 3'd3, 3'd1);
    rom[2] = mk(1, 0, 3'd0, 3'd0, 3'd0); rom[3] = '0;
    ab = addr_q.size();
    play_song("seq", 3'd3);
    check("seq_addr_len", addr_q.size() - ab, 3);
    if (addr_q.size() - ab == 3)
      check("seq_addr_trace", {addr_q[ab], addr_q[ab + 1], addr_q[ab + 2]}, {2'd1, 2'd2, 2'd0});

    // rests
    rom[0] = mk(0, 1, 3'd3, 3'd2, 3'd0); rom[1] = mk(0, 0, 3'd2, 3'd7, 3'd3);
    rom[2] = mk(0, 0, 3'd1, 3'd1, 3'd1); rom[3] = mk(1, 0, 3'd0, 3'd0, 3'd0);
    play_song("rest", 3'd5);

    // no END marker: the song ends after the last address
    rom[0] = mk(0, 0, 3'd1, 3'd2, 3'd3); rom[1] = mk(0, 0, 3'd2, 3'd3, 3'd4);
    rom[2] = mk(0, 0, 3'd3, 3'd4, 3'd5); rom[3] = mk(0, 0, 3'd6, 3'd6, 3'd6);
    play_song("addr_end", 3'd7);

    for (int k = 0; k < 4; k++) begin
      for (int a = 0; a < 4; a++) begin
        w = 16'($urandom);
        w[15] = ($urandom_range(0, 3) == 0);
        rom[a] = w;
      end
      play_song($sformatf("rnd%0d", k), 3'($urandom));
    end

    // looping
    rom[0] = mk(0, 0, 3'd2, 3'd1, 3'd0); rom[1] = mk(0, 0, 3'd3, 3'd2, 3'd1);
    rom[2] = mk(0, 0, 3'd4, 3'd3, 3'd2); rom[3] = mk(1, 0, 3'd0, 3'd0, 3'd0);
    loop = 1'b1; full_note_cfg = 3'd2;
    ab = addr_q.size(); cb = cap_q.size(); db = done_cnt;
    pulse_start();
    wait_notes(cb + 4, "loop_second_pass");
    check("loop_no_done", done_cnt - db, 0);
    check("loop_addr_wrap", addr_q.size() - ab >= 4, 1'b1);
    if (addr_q.size() - ab >= 4)
      check("loop_addr_3_to_0", {addr_q[ab + 2], addr_q[ab + 3]}, {2'd3, 2'd0});
    loop = 1'b0;
    wait_done(db + 1, "loop_done");
    tick(2);
    check("loop_notes", cap_q.size() - cb, 6);
    check_idle("loop_end");

    // pause in PLAY, then in GAP
    rom[0] = mk(0, 0, 3'd4, 3'd0, 3'd2); rom[1] = mk(0, 0, 3'd5, 3'd3, 3'd1);
    rom[2] = mk(1, 0, 3'd0, 3'd0, 3'd0);
    db = done_cnt;
    full_note_cfg = 3'd1;
    pulse_start();
    wait_en(1'b1, "pause_note_start");
    begin
      int n = 0;
      while (snd_over !== 1'b0 && n < 50) begin tick(1); n++; end
      check("pause_gen_started", snd_over, 1'b0);
    end
    pause = 1'b1;
    tick(1);
    check("pause_en_low", snd_en, 1'b0);
    check("pause_mute", mute, 1'b1);
    tick(3);
    check("pause_hold", {snd_en, busy, rom_addr}, {1'b0, 1'b1, 2'd0});
    pause = 1'b0;
    tick(1);
    check("resume_en", snd_en, 1'b1);
    check("resume_fields", {snd_full_note, snd_octave, snd_note, snd_length, mute, rom_addr},
          {3'd1, 3'd4, 3'd0, 3'd2, 1'b0, 2'd0});
    wait_en(1'b0, "pause_note_end");
    pause = 1'b1;
    tick(GAP + 3);
    check("gap_pause_hold", {snd_en, busy, rom_addr}, {1'b0, 1'b1, 2'd0});
    pause = 1'b0;
    tick(1);
    check("gap_resume_addr", rom_addr, 2'd1);
    wait_en(1'b1, "gap_resume_note");
    check("gap_resume_fields", {snd_octave, snd_note, snd_length}, {3'd5, 3'd3, 3'd1});
    wait_done(db + 1, "pause_done");
    tick(2);

    // stop mid-note
    db = done_cnt;
    pulse_start();
    wait_en(1'b1, "stop_note_start");
    tick(1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check_idle("stop");
    tick(30);
    check("stop_no_done", done_cnt - db, 0);
    check("stop_stays_idle", busy, 1'b0);

    // stop wins over start
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check_idle("stop_start");
    tick(5);
    check("stop_start_idle", {busy, snd_en}, 2'b00);

    // start during playback is ignored
    cb = cap_q.size(); db = done_cnt;
    pulse_start();
    begin
      int n = 0;
      while ((rom_addr !== 2'd1 || snd_en !== 1'b1) && n < 200) begin tick(1); n++; end
      check("restart_reach", {rom_addr, snd_en}, {2'd1, 1'b1});
    end
    pulse_start();
    check("restart_addr", rom_addr, 2'd1);
    check("restart_fields", {snd_octave, snd_note}, {3'd5, 3'd3});
    wait_done(db + 1, "restart_done");
    tick(2);
    check("restart_notes", cap_q.size() - cb, 2);

    // asynchronous reset mid-note
    pulse_start();
    wait_en(1'b1, "rst_note_start");
    #2 rst = 1'b1;
    #1 check_idle("async_rst");
    tick(1);
    rst = 1'b0;
    tick(3);
    check_idle("after_rst");

    check("done_with_busy", done_busy, 0);
    check("fields_constant", field_chg, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
